// File: rtl/matrix_pkg.sv
// Shared constants and types for the matrix-product datapath: bank geometry,
// reader FSM states and the 16-bit operand lane layout used by the operand path.
package matrix_pkg;

    localparam int N_SLOTS = 9;
    localparam int DATA_W  = 32;
    localparam int SEL_W   = 4;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Operand word packs A in the low half and B in the high half.
    localparam int LANE_W = 16;
    localparam int A_LSB  = 0;
    localparam int A_MSB  = A_LSB + LANE_W - 1;
    localparam int B_LSB  = LANE_W;
    localparam int B_MSB  = B_LSB + LANE_W - 1;

endpackage

// File: rtl/result_stream_reader_if.sv
// Valid/ready result stream carrying one bank slot per transfer.
interface result_stream_reader_if #(
    parameter int DATA_W = 32,
    parameter int SEL_W  = 4
);
    logic [DATA_W-1:0] data;
    logic [SEL_W-1:0]  index;
    logic              last;
    logic              valid;
    logic              ready;

    modport master (output data, index, last, valid, input ready);
    modport slave  (input data, index, last, valid, output ready);
endinterface

// File: rtl/result_stream_reader.sv
// Walks the result bank slot by slot and streams each word downstream,
// one frame of N_SLOTS words per start request.
module result_stream_reader
    import matrix_pkg::*;
#(
    parameter int N_SLOTS = matrix_pkg::N_SLOTS,
    parameter int DATA_W  = matrix_pkg::DATA_W,
    parameter int SEL_W   = matrix_pkg::SEL_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic [SEL_W-1:0]      rd_sel,
    input  logic [DATA_W-1:0]     rd_data,
    result_stream_reader_if.master m,
    output logic                  busy,
    output logic                  done
);

    localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(N_SLOTS - 1);

    state_t            state, state_n;
    logic [SEL_W-1:0]  ptr, ptr_n;
    logic [DATA_W-1:0] data_n;
    logic [SEL_W-1:0]  index_n;
    logic              last_n, valid_n, done_n;

    assign rd_sel = ptr;

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        data_n  = m.data;
        index_n = m.index;
        last_n  = m.last;
        valid_n = m.valid;
        done_n  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    data_n  = rd_data;
                    index_n = '0;
                    last_n  = (N_SLOTS == 1);
                    valid_n = 1'b1;
                    ptr_n   = (N_SLOTS == 1) ? '0 : SEL_W'(1);
                    state_n = SEND;
                end
            end
            SEND: begin
                if (m.valid && m.ready) begin
                    if (m.last) begin
                        valid_n = 1'b0;
                        last_n  = 1'b0;
                        ptr_n   = '0;
                        done_n  = 1'b1;
                        state_n = IDLE;
                    end else begin
                        data_n  = rd_data;
                        index_n = ptr;
                        last_n  = (ptr == LAST_SLOT);
                        // Wrap early so rd_sel never points past the last slot.
                        ptr_n   = (ptr == LAST_SLOT) ? '0 : ptr + SEL_W'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            ptr     <= '0;
            m.data  <= '0;
            m.index <= '0;
            m.last  <= 1'b0;
            m.valid <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            ptr     <= ptr_n;
            m.data  <= data_n;
            m.index <= index_n;
            m.last  <= last_n;
            m.valid <= valid_n;
            busy    <= (state_n == SEND);
            done    <= done_n;
        end
    end

endmodule

// File: tb/tb_result_stream_reader.sv
// Directed bench for result_stream_reader: bank model, frame collector, stalls,
// ignored start, back-to-back frames, mid-frame reset and live bank update.
module tb_result_stream_reader;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  rd_sel;
    logic [31:0] rd_data;
    logic        busy;
    logic        done;
    logic [31:0] bank [16];

    int total;
    int passes;

    result_stream_reader_if #(.DATA_W(32), .SEL_W(4)) s ();

    result_stream_reader dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .rd_sel  (rd_sel),
        .rd_data (rd_data),
        .m       (s),
        .busy    (busy),
        .done    (done)
    );

    assign rd_data = bank[rd_sel];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passes++;
        end else begin
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic fill_bank();
        for (int k = 0; k < 16; k++) bank[k] = 32'h0000_0100 + k;
    endtask

    logic [31:0] got_data [16];
    logic [3:0]  got_idx  [16];

    // Runs one frame for a fixed window, recording every accepted word.
    task automatic run_frame(input int stall_slot, input int stall_n, input int start_slot,
                             input int poke_slot, output int nwords, output int vcycles,
                             output int ndone);
        int stalls_left;
        stalls_left = stall_n;
        nwords = 0; vcycles = 0; ndone = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < 18; cyc++) begin
            if (done) ndone++;
            start = 1'b0;
            s.ready = 1'b1;
            if (s.valid) begin
                vcycles++;
                if (int'(s.index) == start_slot) start = 1'b1;
                if (int'(s.index) == poke_slot) bank[7] = 32'hDEAD_BEEF;
                if (int'(s.index) == stall_slot && stalls_left > 0) begin
                    s.ready = 1'b0;
                    stalls_left--;
                    check("stall_hold_data", s.data, 32'h0000_0104);
                end
                if (s.ready && nwords < 16) begin
                    got_data[nwords] = s.data;
                    got_idx[nwords]  = s.index;
                    nwords++;
                end
            end
            @(negedge clk);
        end
        start = 1'b0;
        s.ready = 1'b1;
    endtask

    initial begin
        int nw, vc, nd, budget;
        total = 0; passes = 0;
        reset = 1'b0; start = 1'b0; s.ready = 1'b1;
        fill_bank();

        // Reset state
        #12;
        check("rst_valid", {31'd0, s.valid}, 32'd0);
        check("rst_data",  s.data, 32'd0);
        check("rst_index", {28'd0, s.index}, 32'd0);
        check("rst_busy_done", {30'd0, busy, done}, 32'd0);
        check("rst_rd_sel", {28'd0, rd_sel}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Frame with ready held high: exact cycle-by-cycle timing
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            check("f1_valid", {31'd0, s.valid}, 32'd1);
            check("f1_data", s.data, 32'h0000_0100 + i);
            check("f1_index", {28'd0, s.index}, i);
            check("f1_last", {31'd0, s.last}, (i == 8) ? 32'd1 : 32'd0);
            check("f1_busy_done", {30'd0, busy, done}, 32'd2);
            @(negedge clk);
        end
        check("f1_done", {31'd0, done}, 32'd1);
        check("f1_idle_after", {30'd0, s.valid, busy}, 32'd0);
        @(negedge clk);
        check("f1_done_pulse", {31'd0, done}, 32'd0);

        // Three stall cycles on slot 4
        run_frame(4, 3, -1, -1, nw, vc, nd);
        check("stall_words", nw, 32'd9);
        check("stall_cycles", vc, 32'd12);
        check("stall_done", nd, 32'd1);
        for (int i = 0; i < 9; i++) begin
            check("stall_seq_data", got_data[i], 32'h0000_0100 + i);
            check("stall_seq_idx", {28'd0, got_idx[i]}, i);
        end

        // start during SEND is ignored
        run_frame(-1, 0, 2, -1, nw, vc, nd);
        check("ign_words", nw, 32'd9);
        check("ign_done", nd, 32'd1);
        check("ign_idle", {30'd0, s.valid, busy}, 32'd0);

        // start in the done cycle begins the next frame immediately
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        budget = 0;
        while (!done && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        check("b2b_done_seen", {31'd0, done}, 32'd1);
        check("b2b_gap_valid", {31'd0, s.valid}, 32'd0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("b2b_valid", {31'd0, s.valid}, 32'd1);
        check("b2b_index", {28'd0, s.index}, 32'd0);
        check("b2b_data", s.data, 32'h0000_0100);
        repeat (12) @(negedge clk);

        // Asynchronous reset at slot 5
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        budget = 0;
        while (!(s.valid && s.index == 4'd5) && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        check("rst5_reached", {28'd0, s.index}, 32'd5);
        reset = 1'b0;
        #1;
        check("rst5_valid", {31'd0, s.valid}, 32'd0);
        check("rst5_done", {31'd0, done}, 32'd0);
        check("rst5_ptr", {28'd0, rd_sel}, 32'd0);
        check("rst5_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst5_no_done", {31'd0, done}, 32'd0);
        run_frame(-1, 0, -1, -1, nw, vc, nd);
        check("rst5_first", got_data[0], 32'h0000_0100);
        check("rst5_words", nw, 32'd9);

        // Bank rewrite of slot 7 while slot 3 is presented
        run_frame(-1, 0, -1, 3, nw, vc, nd);
        check("poke_words", nw, 32'd9);
        check("poke_slot6", got_data[6], 32'h0000_0106);
        check("poke_slot7", got_data[7], 32'hDEAD_BEEF);
        check("poke_slot8", got_data[8], 32'h0000_0108);
        fill_bank();

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule

// File: doc/result_stream_reader.md
# result_stream_reader

Reads the nine 32-bit result slots of the matrix-product register bank and streams them out in slot order over a valid/ready interface. It is the read-side counterpart of the dot-product write path. Dot_product drives `sel` and data into the bank; this block drives the bank's read select and serialises the slots to a downstream consumer such as a host bridge or the next matrix stage. A single start pulse emits one frame of 9 words, with sustained throughput of 1 word per cycle.

## Interface
Parameters:
- N_SLOTS, 9, number of result slots per frame (3x3 matrix)
- DATA_W, 32, slot width
- SEL_W, 4, slot select width; must satisfy 2**SEL_W >= N_SLOTS

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low; 0 resets the block
- start  in  1  frame request; sampled only in IDLE
- rd_sel  out  SEL_W  read select into the register bank
- rd_data  in  DATA_W  bank word at rd_sel, combinational, valid in the same cycle
- m_data  out  DATA_W  streamed slot value
- m_index  out  SEL_W  slot number of m_data
- m_last  out  1  high with slot N_SLOTS-1
- m_valid  out  1  output word valid
- m_ready  in  1  consumer accepts; a transfer occurs when m_valid && m_ready
- busy  out  1  high in SEND
- done  out  1  one-cycle pulse after the last transfer

## Operation
- States: IDLE and SEND. ptr is a SEL_W counter, and rd_sel = ptr.
- Reset values: state=IDLE, ptr=0, m_valid=0, m_data=0, m_index=0, m_last=0, busy=0, done=0.
- IDLE with start=1 (ptr is 0):
  - capture m_data<=rd_data (slot 0), m_index<=0, m_last<=(N_SLOTS==1)
  - m_valid<=1, ptr<=1, go to SEND
- SEND, m_valid && !m_ready:
  - hold m_data, m_index, m_last and m_valid unchanged
  - ptr unchanged
- SEND, transfer with m_last=0:
  - capture rd_data at slot ptr, m_index<=ptr, m_last<=(ptr==N_SLOTS-1)
  - ptr<=ptr+1, m_valid stays 1
- SEND, transfer with m_last=1:
  - m_valid<=0, m_last<=0, ptr<=0, done<=1, go to IDLE
- start in SEND is ignored; there is no queueing.
- start in the cycle where done=1: accepted, because the state is already IDLE.
- ptr never exceeds N_SLOTS-1 while driving rd_sel. Slots N_SLOTS..2**SEL_W-1 are never read.
- The bank contents are not snapshotted. A bank write during a frame is seen by slots not yet captured.
- Reset asserted mid-frame: all outputs return to their reset values immediately (asynchronously). The partial frame is dropped and no done pulse is issued.

## Timing
- start at edge k -> m_valid=1 with slot 0 from edge k+1.
- With m_ready held at 1: slots 0..8 are on edges k+1..k+9, m_last on slot 8, done=1 for one cycle after edge k+10.
- Each stall cycle of m_ready=0 adds exactly one cycle. There are no bubbles otherwise.
- Minimum frame-to-frame spacing: start in the done cycle gives one idle cycle between the last word and the next slot 0.
- done is registered, high for exactly one cycle.
- busy is registered and equals (state==SEND).
- m_* outputs come directly from registers. m_ready has no combinational path to any output except through rd_sel? No: rd_sel is registered ptr, so the block has no combinational paths at all.

## Structure
- Shared package matrix_pkg holds:
  - N_SLOTS, DATA_W, SEL_W
  - the state enum {IDLE, SEND}
  - the 16-bit operand lane constants (A in bits [15:0], B in bits [31:16]), shared with the operand path
- No sub-module is needed: one FSM always_ff block with the ptr counter and output register.
- Top-level integration: rd_sel drives the bank read mux; the bank's out[rd_sel] feeds rd_data.

## Test plan
- Bank slot k = 32'h0000_0100+k, start pulse, m_ready=1 -> 9 transfers: values 0x100..0x108, m_index 0..8, m_last only on 0x108, done one cycle later.
- Same bank, m_ready low for 3 cycles while slot 4 is presented -> slot 4 (0x104) held stable with m_valid=1; the frame takes exactly 12 data cycles and no slot is duplicated or skipped.
- start pulsed again during SEND at slot 2 -> ignored; exactly 9 words, one done.
- start asserted in the done cycle -> second frame begins the next cycle with slot 0 and m_index=0.
- reset driven to 0 at slot 5 -> m_valid, done and ptr are 0 at once; after release, start yields slot 0 first.
- Bank slot 7 rewritten to 0xDEAD_BEEF while slot 3 is on the output -> the streamed slot 7 equals 0xDEAD_BEEF.
